// File: rtl/vga_scanout.sv
// vga_scanout: raster scan-out stage for the 320x240 RGB332 framebuffer.
// It generates 640x480@60 VGA timing from CLOCK_50 using a divide-by-2
// pixel enable, and issues framebuffer read coordinates in 640x480 space.
// The returned RGB332 pixel is expanded to 24-bit colour, aligned with sync
// and blank.
//
// Ports:
//   CLOCK_50     in   system clock, 50 MHz
//   reset        in   asynchronous active-low reset
//   pixel_in     in   RGB332 read data, valid 1 CLOCK_50 cycle after read_x/read_y
//   read_x       out  framebuffer read column, 0 outside the visible area
//   read_y       out  framebuffer read row, 0 outside the visible area
//   VGA_CLK      out  25 MHz pixel clock; rises mid-pixel
//   VGA_HS       out  horizontal sync, active low
//   VGA_VS       out  vertical sync, active low
//   VGA_BLANK_N  out  high during visible pixels
//   VGA_SYNC_N   out  tied low
//   VGA_R/G/B    out  8-bit colour to the DAC
//   vblank       out  high while the line counter is in vertical blanking
//   frame_start  out  one-cycle pulse after the counters wrap to (0,0)
module vga_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  pixel_in,
    output logic [10:0] read_x,
    output logic [10:0] read_y,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        vblank,
    output logic        frame_start
);

    localparam int unsigned CW      = 11;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic          pix_en;
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          h_wrap;
    logic          v_wrap;
    logic          active;
    logic          hs_raw;
    logic          vs_raw;
    logic [23:0]   rgb_c;

    // RGB332 to RGB888 by bit replication so full-scale maps to 0xFF.
    function automatic logic [23:0] expand(input logic [7:0] p);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = p[7:5];
        g = p[4:2];
        b = p[1:0];
        return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
    endfunction

    // Counter next-state, sync decode and read address decode.
    always_comb begin
        h_wrap = (h_count == H_LAST);
        v_wrap = (v_count == V_LAST);
        h_next = h_wrap ? '0 : h_count + CW'(1);
        v_next = v_count;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v_count + CW'(1);
        end
        active = (h_count < H_VIS) && (v_count < V_VIS);
        hs_raw = !((h_count >= HS_START) && (h_count < HS_END));
        vs_raw = !((v_count >= VS_START) && (v_count < VS_END));
        rgb_c  = active ? expand(pixel_in) : 24'h0;
    end

    assign read_x     = active ? h_count : '0;
    assign read_y     = active ? v_count : '0;
    assign vblank     = (v_count >= V_VIS);
    assign VGA_CLK    = pix_en;
    assign VGA_SYNC_N = 1'b0;

    // Pixel enable, raster counters and the one-pixel-delayed output stage.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            pix_en      <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= !pix_en;
            frame_start <= pix_en && h_wrap && v_wrap;
            if (pix_en) begin
                h_count     <= h_next;
                v_count     <= v_next;
                VGA_HS      <= hs_raw;
                VGA_VS      <= vs_raw;
                VGA_BLANK_N <= active;
                VGA_R       <= rgb_c[23:16];
                VGA_G       <= rgb_c[15:8];
                VGA_B       <= rgb_c[7:0];
            end
        end
    end

endmodule
